// File: rtl/gpr_issue_arbiter_pkg.sv
// Shared types and helpers for the GPR issue arbiter: wavefront vectors/ids,
// output-register state, and the debug view of the internal state.
package gpr_issue_arbiter_pkg;

  localparam int WF_PER_CU    = 40;
  localparam int WF_ID_LENGTH = 6;

  typedef logic [WF_PER_CU-1:0]    wf_vec_t;
  typedef logic [WF_ID_LENGTH-1:0] wf_id_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } issue_state_e;

  typedef struct packed {
    issue_state_e state;
    wf_id_t       rr_ptr;
    logic         dec_valid;
    wf_id_t       dec_wfid;
  } arb_dbg_t;

  function automatic wf_id_t next_wfid(input wf_id_t w);
    return (w == wf_id_t'(WF_PER_CU - 1)) ? '0 : w + wf_id_t'(1);
  endfunction

  function automatic logic id_in_range(input wf_id_t w);
    return w < wf_id_t'(WF_PER_CU);
  endfunction

  function automatic wf_vec_t wf_onehot(input wf_id_t w);
    return wf_vec_t'(1) << w;
  endfunction

endpackage

// File: rtl/gpr_issue_arbiter_rr_priority_encoder.sv
// Round-robin find-first-set: rotate the request vector so ptr lands at bit 0,
// pick the lowest set bit, then map the offset back to a wavefront id.
module rr_priority_encoder
  import gpr_issue_arbiter_pkg::*;
(
  input  logic [WF_PER_CU-1:0]    req,
  input  logic [WF_ID_LENGTH-1:0] ptr,
  output logic                    found,
  output logic [WF_ID_LENGTH-1:0] id
);

  logic [2*WF_PER_CU-1:0]  dbl;
  logic [WF_PER_CU-1:0]    rot;
  logic [WF_ID_LENGTH-1:0] off;
  logic [WF_ID_LENGTH:0]   sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[WF_PER_CU-1:0];
    found = 1'b0;
    off   = '0;
    // Scan downward so the last hit written is the lowest set offset.
    for (int i = WF_PER_CU - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = wf_id_t'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (WF_ID_LENGTH+1)'(WF_PER_CU)) sum = sum - (WF_ID_LENGTH+1)'(WF_PER_CU);
    id = sum[WF_ID_LENGTH-1:0];
  end

endmodule

// File: rtl/gpr_issue_arbiter.sv
// Round-robin issue scheduler between the GPR dependency table and the FU
// dispatch port, with a per-wavefront lock held until the next decode settles.
module gpr_issue_arbiter
  import gpr_issue_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    ready_arry_gpr,
  input  logic [WF_PER_CU-1:0]    valid_entry,
  input  logic                    f_decode_valid,
  input  logic [WF_ID_LENGTH-1:0] f_decode_wfid,
  input  logic                    flush_valid,
  input  logic [WF_ID_LENGTH-1:0] flush_wfid,
  input  logic                    fu_ready,
  output logic                    issue_valid,
  output logic [WF_ID_LENGTH-1:0] issue_wfid,
  output logic [WF_PER_CU-1:0]    issue_onehot,
  output logic [WF_PER_CU-1:0]    lock_arry,
  output arb_dbg_t                dbg
);

  // Handshake: a dispatch happens on any rising edge where issue_valid and
  // fu_ready are both high; issue_wfid is stable while valid is high and
  // ready is low, unless a flush of that wavefront withdraws the grant.

  issue_state_e state_q;
  wf_id_t       rr_ptr;
  wf_vec_t      lock_q;
  wf_vec_t      lock_n;
  logic         dec_valid_q;
  wf_id_t       dec_wfid_q;

  logic    flush_hit;
  logic    accept;
  logic    withdraw;
  wf_vec_t elig;
  wf_id_t  search_ptr;
  logic    win_found;
  wf_id_t  win_id;

  always_comb begin
    flush_hit  = flush_valid && id_in_range(flush_wfid);
    accept     = (state_q == ST_PRESENT) && fu_ready;
    withdraw   = (state_q == ST_PRESENT) && !fu_ready && flush_hit && (flush_wfid == issue_wfid);
    elig       = ready_arry_gpr & valid_entry & ~lock_q;
    if (accept)    elig = elig & ~wf_onehot(issue_wfid);
    if (flush_hit) elig = elig & ~wf_onehot(flush_wfid);
    // A same-edge follow-on grant searches from just past the accepted wavefront.
    search_ptr = accept ? next_wfid(issue_wfid) : rr_ptr;
  end

  always_comb begin
    lock_n = lock_q;
    if (dec_valid_q) lock_n = lock_n & ~wf_onehot(dec_wfid_q);
    if (accept && !(flush_hit && (flush_wfid == issue_wfid))) lock_n = lock_n | wf_onehot(issue_wfid);
    if (flush_hit) lock_n = lock_n & ~wf_onehot(flush_wfid);
  end

  rr_priority_encoder u_rr_enc (
    .req   (elig),
    .ptr   (search_ptr),
    .found (win_found),
    .id    (win_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_valid  <= 1'b0;
      issue_wfid   <= '0;
      issue_onehot <= '0;
      rr_ptr       <= '0;
      lock_q       <= '0;
      dec_valid_q  <= 1'b0;
      dec_wfid_q   <= '0;
    end else begin
      lock_q      <= lock_n;
      dec_valid_q <= f_decode_valid && id_in_range(f_decode_wfid)
                     && !(flush_hit && (flush_wfid == f_decode_wfid));
      dec_wfid_q  <= f_decode_wfid;
      if (accept) rr_ptr <= next_wfid(issue_wfid);

      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q      <= ST_PRESENT;
            issue_valid  <= 1'b1;
            issue_wfid   <= win_id;
            issue_onehot <= wf_onehot(win_id);
          end
        end
        ST_PRESENT: begin
          if (accept || withdraw) begin
            if (win_found) begin
              issue_wfid   <= win_id;
              issue_onehot <= wf_onehot(win_id);
            end else begin
              state_q      <= ST_IDLE;
              issue_valid  <= 1'b0;
              issue_onehot <= '0;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          issue_valid  <= 1'b0;
          issue_onehot <= '0;
        end
      endcase
    end
  end

  assign lock_arry = lock_q;
  assign dbg       = '{state: state_q, rr_ptr: rr_ptr, dec_valid: dec_valid_q, dec_wfid: dec_wfid_q};

endmodule

// File: tb/tb_gpr_issue_arbiter.sv
// Directed bench for gpr_issue_arbiter: a vector table for the main flow plus
// hand sequences for wrap, flush, accept+flush and mid-handshake reset.
module tb_gpr_issue_arbiter;
  import gpr_issue_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] ready_arry_gpr, valid_entry;
  logic        f_decode_valid, flush_valid, fu_ready;
  logic [5:0]  f_decode_wfid, flush_wfid;
  logic        issue_valid;
  logic [5:0]  issue_wfid;
  logic [39:0] issue_onehot, lock_arry;
  arb_dbg_t    dbg;

  int checks = 0;
  int errors = 0;
  int dispatch_cnt = 0;
  logic [5:0] exp_q[$];

  gpr_issue_arbiter dut (
    .clk(clk), .rst(rst), .ready_arry_gpr(ready_arry_gpr), .valid_entry(valid_entry),
    .f_decode_valid(f_decode_valid), .f_decode_wfid(f_decode_wfid),
    .flush_valid(flush_valid), .flush_wfid(flush_wfid), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_wfid(issue_wfid), .issue_onehot(issue_onehot),
    .lock_arry(lock_arry), .dbg(dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [39:0] ready;
    logic [39:0] valid;
    logic        fu;
    logic        dv;
    logic [5:0]  did;
    logic        fv;
    logic [5:0]  fid;
    logic        ev;
    logic [5:0]  ewfid;
    logic [39:0] elock;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t row(input logic [39:0] m, input logic [39:0] v, input logic fu,
                               input logic dv, input logic [5:0] did,
                               input logic fv, input logic [5:0] fid,
                               input logic ev, input logic [5:0] ew, input logic [39:0] el);
    vec_t r;
    r.ready = m; r.valid = v; r.fu = fu; r.dv = dv; r.did = did;
    r.fv = fv; r.fid = fid; r.ev = ev; r.ewfid = ew; r.elock = el;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Driver: one clock with inputs already applied; the accept monitor feeds the scoreboard.
  task automatic step();
    logic       acc;
    logic [5:0] acc_id;
    logic [5:0] e;
    acc    = issue_valid && fu_ready;
    acc_id = issue_wfid;
    @(posedge clk);
    #1;
    if (acc) begin
      dispatch_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("accept_order", 64'(acc_id), 64'(e));
      end
    end
  endtask

  task automatic idle_inputs();
    ready_arry_gpr = '0; valid_entry = '0; fu_ready = 1'b0;
    f_decode_valid = 1'b0; f_decode_wfid = '0; flush_valid = 1'b0; flush_wfid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_grant(input string name, input logic ev, input logic [5:0] ew);
    check({name, "_valid"}, 64'(issue_valid), 64'(ev));
    if (ev) begin
      check({name, "_wfid"}, 64'(issue_wfid), 64'(ew));
      check({name, "_onehot"}, 64'(issue_onehot), 64'(40'd1 << ew));
    end else begin
      check({name, "_onehot"}, 64'(issue_onehot), 64'd0);
    end
  endtask

  logic [39:0] m;
  int          d0;

  initial begin
    // Vector table: decode/flush/stall flow from reset.
    tbl[0]  = row(40'h0,   40'h0,   1, 0, 0,  0, 0,  0, 0, 40'h0);
    tbl[1]  = row(40'h88,  40'h88,  1, 0, 0,  0, 0,  1, 3, 40'h0);
    tbl[2]  = row(40'h88,  40'h88,  1, 0, 0,  0, 0,  1, 7, 40'h08);
    tbl[3]  = row(40'h88,  40'h88,  1, 0, 0,  0, 0,  0, 0, 40'h88);
    tbl[4]  = row(40'h88,  40'h88,  1, 0, 0,  0, 0,  0, 0, 40'h88);
    tbl[5]  = row(40'h400, 40'h0,   1, 0, 0,  0, 0,  0, 0, 40'h88);
    tbl[6]  = row(40'h400, 40'h800, 1, 0, 0,  0, 0,  0, 0, 40'h88);
    tbl[7]  = row(40'h20,  40'h20,  0, 0, 0,  0, 0,  1, 5, 40'h88);
    tbl[8]  = row(40'h24,  40'h24,  0, 0, 0,  0, 0,  1, 5, 40'h88);
    tbl[9]  = row(40'h24,  40'h24,  0, 0, 0,  0, 0,  1, 5, 40'h88);
    tbl[10] = row(40'h24,  40'h24,  0, 0, 0,  0, 0,  1, 5, 40'h88);
    tbl[11] = row(40'h24,  40'h24,  0, 0, 0,  0, 0,  1, 5, 40'h88);
    tbl[12] = row(40'h24,  40'h24,  1, 0, 0,  0, 0,  1, 2, 40'hA8);
    tbl[13] = row(40'h24,  40'h24,  1, 0, 0,  0, 0,  0, 0, 40'hAC);
    tbl[14] = row(40'h8,   40'h8,   1, 1, 3,  0, 0,  0, 0, 40'hAC);
    tbl[15] = row(40'h8,   40'h8,   1, 0, 0,  0, 0,  0, 0, 40'hA4);
    tbl[16] = row(40'h8,   40'h8,   1, 0, 0,  0, 0,  1, 3, 40'hA4);
    tbl[17] = row(40'h0,   40'h0,   1, 0, 0,  0, 0,  0, 0, 40'hAC);
    tbl[18] = row(40'h0,   40'h0,   1, 1, 63, 1, 45, 0, 0, 40'hAC);
    tbl[19] = row(40'h0,   40'h0,   1, 0, 0,  0, 0,  0, 0, 40'hAC);
    tbl[20] = row(40'h0,   40'h0,   1, 0, 0,  1, 7,  0, 0, 40'h2C);

    do_reset();
    check("rst_valid",  64'(issue_valid), 64'd0);
    check("rst_wfid",   64'(issue_wfid), 64'd0);
    check("rst_onehot", 64'(issue_onehot), 64'd0);
    check("rst_lock",   64'(lock_arry), 64'd0);
    check("rst_rr_ptr", 64'(dbg.rr_ptr), 64'd0);
    check("rst_dec_q",  64'(dbg.dec_valid), 64'd0);

    for (int i = 0; i < 21; i++) begin
      ready_arry_gpr = tbl[i].ready; valid_entry = tbl[i].valid; fu_ready = tbl[i].fu;
      f_decode_valid = tbl[i].dv; f_decode_wfid = tbl[i].did;
      flush_valid = tbl[i].fv; flush_wfid = tbl[i].fid;
      step();
      check_grant($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ewfid);
      check($sformatf("vec%0d_lock", i), 64'(lock_arry), 64'(tbl[i].elock));
    end

    // Wrap: accept 37 moves the pointer to 38; {0,38,39} must issue 38, 39, 0.
    do_reset();
    exp_q.push_back(6'd37); exp_q.push_back(6'd38);
    exp_q.push_back(6'd39); exp_q.push_back(6'd0);
    m = 40'd1 << 37;
    ready_arry_gpr = m; valid_entry = m; fu_ready = 1'b1;
    step();
    check_grant("wrap_37", 1'b1, 6'd37);
    m = (40'd1 << 38) | (40'd1 << 39) | 40'd1;
    ready_arry_gpr = m; valid_entry = m;
    step();
    check_grant("wrap_38", 1'b1, 6'd38);
    step();
    check_grant("wrap_39", 1'b1, 6'd39);
    step();
    check_grant("wrap_0", 1'b1, 6'd0);
    step();
    check_grant("wrap_end", 1'b0, 6'd0);
    check("wrap_lock", 64'(lock_arry), 64'(40'hE0_0000_0001));
    check("wrap_rr_ptr", 64'(dbg.rr_ptr), 64'd1);
    check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush of a stalled grant: withdraw to another winner, then to IDLE.
    do_reset();
    ready_arry_gpr = 40'h3000; valid_entry = 40'h3000; fu_ready = 1'b0;
    step();
    check_grant("fl_present12", 1'b1, 6'd12);
    flush_valid = 1'b1; flush_wfid = 6'd12;
    step();
    check_grant("fl_withdraw12", 1'b1, 6'd13);
    check("fl_lock_a", 64'(lock_arry), 64'd0);
    flush_valid = 1'b0; ready_arry_gpr = '0; valid_entry = '0;
    step();
    check_grant("fl_hold13", 1'b1, 6'd13);
    flush_valid = 1'b1; flush_wfid = 6'd13;
    step();
    check_grant("fl_withdraw13", 1'b0, 6'd0);
    check("fl_lock_b", 64'(lock_arry), 64'd0);
    flush_valid = 1'b0;

    // Accept and flush of 14 together: dispatch happens, no lock left behind.
    ready_arry_gpr = 40'h4000; valid_entry = 40'h4000; fu_ready = 1'b1;
    step();
    check_grant("af_present14", 1'b1, 6'd14);
    d0 = dispatch_cnt;
    flush_valid = 1'b1; flush_wfid = 6'd14;
    step();
    check_grant("af_after", 1'b0, 6'd0);
    check("af_lock", 64'(lock_arry), 64'd0);
    check("af_dispatch", 64'(dispatch_cnt - d0), 64'd1);
    check("af_rr_ptr", 64'(dbg.rr_ptr), 64'd15);
    flush_valid = 1'b0; fu_ready = 1'b0;
    step();
    check_grant("af_regrant14", 1'b1, 6'd14);

    // Reset while PRESENT with locks 0..7 set.
    do_reset();
    ready_arry_gpr = 40'h1FF; valid_entry = 40'h1FF; fu_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check_grant("pre_rst", 1'b1, 6'd8);
    check("pre_rst_lock", 64'(lock_arry), 64'hFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_grant("mid_rst", 1'b0, 6'd0);
    check("mid_rst_wfid", 64'(issue_wfid), 64'd0);
    check("mid_rst_lock", 64'(lock_arry), 64'd0);
    check("mid_rst_rr_ptr", 64'(dbg.rr_ptr), 64'd0);
    check("mid_rst_state", 64'(dbg.state), 64'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
